fir_stream: RTL and testbench

Parametrised, streaming, signed direct-form FIR filter, successor to the fixed 16-tap block. It supports compile-time tap count, data/coefficient widths and output scaling. Coefficients are written at runtime into a shadow bank and committed atomically. A valid-qualified sample stream is accepted with gaps, and outputs are rounded and saturated with a clip flag. It sits between the sample source (ADC/decimator) and downstream DSP. It has no backpressure: the block is always ready.

---
 rtl/fir_stream.sv | 134 +++++++++++++
 tb/tb_fir_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream.sv
// Streaming signed direct-form FIR with shadow/active coefficient banks,
// a three-stage pipeline (products, sum, round/saturate) and no backpressure.
module fir_stream #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      coef_commit,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat
);

  localparam int ADDR_W  = $clog2(TAPS);
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int ACC_W   = DATA_W + COEF_W + $clog2(TAPS);
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [ACC_W:0] RND_BIAS =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [COEF_W-1:0] shadow_reg [TAPS];
  logic signed [COEF_W-1:0] active_reg [TAPS];
  logic signed [DATA_W-1:0] dline_reg  [TAPS];
  logic signed [PROD_W-1:0] prod_next  [TAPS];
  logic signed [PROD_W-1:0] prod_reg   [TAPS];
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [ACC_W-1:0]  sum_reg;
  logic signed [ACC_W:0]    rnd_next;
  logic signed [ACC_W:0]    shifted_next;
  logic [DATA_W-1:0]        out_data_next;
  logic                     out_sat_next;
  logic                     accept_valid_reg;
  logic                     prod_valid_reg;
  logic                     sum_valid_reg;
  logic                     coef_addr_ok;

  assign coef_addr_ok = ({{(32 - ADDR_W){1'b0}}, coef_addr} < 32'(TAPS));

  // Nonblocking copy means a same-edge write lands only in the shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (coef_we && coef_addr_ok)
        shadow_reg[coef_addr] <= coef_data;
      if (coef_commit)
        for (int i = 0; i < TAPS; i++)
          active_reg[i] <= shadow_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++)
        dline_reg[i] <= '0;
    end else if (in_valid) begin
      dline_reg[0] <= in_data;
      for (int i = 1; i < TAPS; i++)
        dline_reg[i] <= dline_reg[i-1];
    end
  end

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_mul
      assign prod_next[gi] = active_reg[gi] * dline_reg[gi];
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < TAPS; i++)
      sum_next = sum_next + ACC_W'(prod_reg[i]);
  end

  // One guard bit above the accumulator keeps the rounding add exact.
  always_comb begin
    rnd_next      = {sum_reg[ACC_W-1], sum_reg} + RND_BIAS;
    shifted_next  = rnd_next >>> OUT_SHIFT;
    out_data_next = shifted_next[DATA_W-1:0];
    out_sat_next  = 1'b0;
    if (shifted_next > SAT_MAX) begin
      out_data_next = SAT_MAX[DATA_W-1:0];
      out_sat_next  = 1'b1;
    end else if (shifted_next < SAT_MIN) begin
      out_data_next = SAT_MIN[DATA_W-1:0];
      out_sat_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_valid_reg <= 1'b0;
      prod_valid_reg   <= 1'b0;
      sum_valid_reg    <= 1'b0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_sat          <= 1'b0;
      sum_reg          <= '0;
      for (int i = 0; i < TAPS; i++)
        prod_reg[i] <= '0;
    end else begin
      accept_valid_reg <= in_valid;
      prod_valid_reg   <= accept_valid_reg;
      sum_valid_reg    <= prod_valid_reg;
      out_valid        <= sum_valid_reg;
      if (accept_valid_reg)
        for (int i = 0; i < TAPS; i++)
          prod_reg[i] <= prod_next[i];
      if (prod_valid_reg)
        sum_reg <= sum_next;
      if (sum_valid_reg) begin
        out_data <= out_data_next;
        out_sat  <= out_sat_next;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// Directed bench for fir_stream: two instances (no shift / shift 15) share the
// coefficient bus; expected outputs are queued at issue and popped by monitors.
module tb_fir_stream;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_commit;
  logic        in_valid_a, in_valid_b;
  logic [15:0] in_data_a, in_data_b;
  logic        out_valid_a, out_valid_b;
  logic [15:0] out_data_a, out_data_b;
  logic        out_sat_a, out_sat_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_stream #(.DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_sat(out_sat_a));

  fir_stream #(.DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_SHIFT(15)) dut_b (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .in_valid(in_valid_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_sat(out_sat_b));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input string tag, input logic [15:0] d, input logic s,
                     inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_output: got %0d with empty queue (cycle %0d)",
               tag, $signed(d), cyc);
    end else begin
      e = q.pop_front();
      $display("%s out cycle=%0d data=%0d sat=%0d exp_data=%0d exp_sat=%0d",
               tag, cyc, $signed(d), s, $signed(e.data), e.sat);
      chk({tag, "_data"}, longint'($signed(d)), longint'($signed(e.data)));
      chk({tag, "_sat"}, longint'(s), longint'(e.sat));
      chk({tag, "_latency"}, longint'(cyc), longint'(e.t));
    end
  endtask

  always @(negedge clk) begin
    if (out_valid_a === 1'b1) mon("A", out_data_a, out_sat_a, q_a);
    if (out_valid_b === 1'b1) mon("B", out_data_b, out_sat_b, q_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  // Drives one sample; y is the exact expected result before saturation.
  task automatic sample(input bit b, input int v, input longint y, input bit push = 1'b1);
    exp_t e;
    e.sat  = 1'b0;
    e.data = 16'(y);
    if (y > 32767)  begin e.data = 16'h7fff; e.sat = 1'b1; end
    if (y < -32768) begin e.data = 16'h8000; e.sat = 1'b1; end
    e.t = cyc + 4;
    if (b) begin
      in_valid_b = 1'b1; in_data_b = 16'(v);
      if (push) q_b.push_back(e);
    end else begin
      in_valid_a = 1'b1; in_data_a = 16'(v);
      if (push) q_a.push_back(e);
    end
    tick();
  endtask

  task automatic wr(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 16'(val);
    tick();
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
  endtask

  task automatic impulse_run();
    for (int i = 0; i < 21; i++)
      sample(0, (i == 0) ? 1 : 0, (i < 16) ? longint'(i + 1) : 0);
  endtask

  initial begin
    longint m;
    rst = 1'b1; coef_we = 0; coef_addr = 0; coef_data = 0; coef_commit = 0;
    in_valid_a = 0; in_valid_b = 0; in_data_a = 0; in_data_b = 0;
    repeat (3) tick();
    chk("reset_out_valid", longint'(out_valid_a), 0);
    chk("reset_out_data", longint'(out_data_a), 0);
    chk("reset_out_sat", longint'(out_sat_a), 0);
    rst = 1'b0;
    tick();

    // Impulse response reads back the coefficients.
    for (int k = 0; k < 16; k++) wr(k, k + 1);
    commit();
    impulse_run();

    // Step with random gaps: triangular partial sums, then decay.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      m = (n < 15) ? n + 1 : 16;
      sample(0, 1, m * (m + 1) / 2);
    end
    for (int j = 1; j <= 16; j++) begin
      repeat ($urandom_range(0, 2)) tick();
      sample(0, 0, 136 - j * (j + 1) / 2);
    end

    // Saturation on both rails, then exactly-at-max without clipping.
    for (int k = 0; k < 16; k++) wr(k, 32767);
    commit();
    for (int n = 0; n < 16; n++) sample(0, 32767, longint'(n + 1) * 32767 * 32767);
    for (int j = 1; j <= 16; j++)
      sample(0, -32768, 32767 * (longint'(16 - j) * 32767 - longint'(j) * 32768));
    for (int j = 1; j <= 16; j++) sample(0, 0, 32767 * longint'(16 - j) * -32768);
    sample(0, 1, 32767);
    sample(0, -1, 0);
    sample(0, 0, 0);

    // Commit boundary.
    for (int k = 0; k < 16; k++) wr(k, (k == 0) ? 1 : 0);
    commit();
    sample(0, 1, 1);
    sample(0, 2, 2);
    sample(0, 3, 3);
    coef_we = 1'b1; coef_addr = 0; coef_data = 16'd2;
    sample(0, 4, 4);
    sample(0, 5, 5);
    sample(0, 6, 6);
    coef_commit = 1'b1;
    sample(0, 7, 14);
    sample(0, 8, 16);
    wr(0, 3);
    coef_we = 1'b1; coef_addr = 0; coef_data = 16'd5; coef_commit = 1'b1;
    tick();
    sample(0, 9, 27);
    commit();
    sample(0, 10, 50);

    // Rounding on the shifted instance.
    wr(0, 16384);
    commit();
    sample(1, 3, 2);
    sample(1, -3, -1);
    sample(1, 1, 1);
    sample(1, -1, 0);

    // Reset mid-stream: only the first three outputs escape before rst.
    for (int i = 0; i < 6; i++) sample(0, 1, 16384, i < 3);
    rst = 1'b1;
    sample(0, 1, 0, 1'b0);
    chk("midreset_out_valid", longint'(out_valid_a), 0);
    chk("midreset_out_data", longint'(out_data_a), 0);
    chk("midreset_out_sat", longint'(out_sat_a), 0);
    rst = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 16; k++) wr(k, k + 1);
    for (int i = 0; i < 17; i++) sample(0, (i == 0) ? 1 : 0, 0);
    commit();
    impulse_run();

    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    repeat (3) tick();
    chk("drain_queue_a", longint'(q_a.size()), 0);
    chk("drain_queue_b", longint'(q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
